// File: rtl/img_stream_pack.sv
`default_nettype none
// ============================================================================
//  Module   : img_stream_pack
//  Purpose  : Gearbox packing IN_WIDTH-bit beats into STR_IMG_WIDTH-bit words
//             for the image stage. A frame's final word is zero-padded.
//  Revision : 1.0  initial release
// ============================================================================
module img_stream_pack #(
    parameter int IN_WIDTH      = 16,
    parameter int STR_IMG_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_WIDTH-1:0]      in_bus,
    input  logic                     in_last,
    input  logic                     in_val,
    output logic                     in_rdy,
    output logic [STR_IMG_WIDTH-1:0] str_img_bus,
    output logic                     str_img_last,
    output logic                     str_img_val,
    input  logic                     str_img_rdy
);

    localparam int RATIO  = STR_IMG_WIDTH / IN_WIDTH;
    localparam int LANE_W = (RATIO > 2) ? $clog2(RATIO) : 1;

    localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [LANE_W-1:0] c_LANE_ONE  = LANE_W'(1);

    generate
        if ((RATIO < 2) || ((STR_IMG_WIDTH % IN_WIDTH) != 0)) begin : g_bad_ratio
            $error("img_stream_pack: STR_IMG_WIDTH must be a multiple (>=2) of IN_WIDTH");
        end
    endgenerate

    logic [LANE_W-1:0]        r_lane;
    logic [STR_IMG_WIDTH-1:0] r_acc;
    logic [STR_IMG_WIDTH-1:0] r_bus;
    logic                     r_val;
    logic                     r_last;

    logic                     w_in_rdy;
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic                     w_complete;
    int unsigned              w_shamt;
    logic [STR_IMG_WIDTH-1:0] w_word;

    assign w_in_rdy   = ~r_val | str_img_rdy;
    assign w_in_fire  = in_val & w_in_rdy;
    assign w_out_fire = r_val & str_img_rdy;
    assign w_complete = w_in_fire & (in_last | (r_lane == c_LAST_LANE));

    // Lanes at and above r_lane are always zero in r_acc, so OR-ing in the
    // current beat both writes its lane and zero-pads a short final word.
    always_comb begin
        w_shamt = int'(r_lane) * IN_WIDTH;
        w_word  = r_acc | (STR_IMG_WIDTH'(in_bus) << w_shamt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= '0;
            r_acc  <= '0;
            r_bus  <= '0;
            r_val  <= 1'b0;
            r_last <= 1'b0;
        end else begin
            if (w_in_fire) begin
                if (w_complete) begin
                    r_lane <= '0;
                    r_acc  <= '0;
                end else begin
                    r_lane <= r_lane + c_LANE_ONE;
                    r_acc  <= w_word;
                end
            end

            // A completing beat reloads the output even while it drains.
            if (w_complete) begin
                r_bus  <= w_word;
                r_val  <= 1'b1;
                r_last <= in_last;
            end else if (w_out_fire) begin
                r_val  <= 1'b0;
                r_last <= 1'b0;
            end
        end
    end

    assign in_rdy       = w_in_rdy;
    assign str_img_bus  = r_bus;
    assign str_img_last = r_last;
    assign str_img_val  = r_val;

endmodule
`default_nettype wire

// File: tb/tb_img_stream_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_img_stream_pack
//  Purpose  : Self-checking bench for img_stream_pack (16 -> 64 bit packing).
//  Revision : 1.0  initial release
// ============================================================================
module tb_img_stream_pack;

    localparam int IW = 16;
    localparam int OW = 64;
    localparam int R  = OW / IW;

    typedef logic [OW:0] word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] in_bus;
    logic          in_last;
    logic          in_val;
    logic          in_rdy;
    logic [OW-1:0] str_img_bus;
    logic          str_img_last;
    logic          str_img_val;
    logic          str_img_rdy;

    img_stream_pack #(.IN_WIDTH(IW), .STR_IMG_WIDTH(OW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_bus       (in_bus),
        .in_last      (in_last),
        .in_val       (in_val),
        .in_rdy       (in_rdy),
        .str_img_bus  (str_img_bus),
        .str_img_last (str_img_last),
        .str_img_val  (str_img_val),
        .str_img_rdy  (str_img_rdy)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    word_t         q_exp[$];
    word_t         q_got[$];
    logic [IW-1:0] m_beats[R];
    int            m_cnt    = 0;
    int            rdy_bad  = 0;
    int            beats_acc = 0;
    logic          s_rdy, s_val, s_last;
    logic [OW-1:0] s_bus;

    // Reference packing: collect beats of a word, build it once it is complete.
    task automatic model_beat(input logic [IW-1:0] d, input logic l);
        logic [OW-1:0] w;
        m_beats[m_cnt] = d;
        m_cnt++;
        if (l || m_cnt == R) begin
            w = '0;
            for (int k = 0; k < m_cnt; k++) w = w | (OW'(m_beats[k]) << (k * IW));
            q_exp.push_back({l, w});
            m_cnt = 0;
        end
    endtask

    // One clock: drive at negedge, sample 1 ns later, return at the next negedge.
    task automatic cycle(input logic v, input logic [IW-1:0] d, input logic l, input logic ordy);
        in_val = v; in_bus = d; in_last = l; str_img_rdy = ordy;
        #1;
        s_rdy = in_rdy; s_val = str_img_val; s_last = str_img_last; s_bus = str_img_bus;
        if (!rst) begin
            if (s_rdy !== (~s_val | ordy)) rdy_bad++;
            if (v && s_rdy) begin
                model_beat(d, l);
                beats_acc++;
            end
            if (s_val && ordy) q_got.push_back({s_last, s_bus});
        end
        @(negedge clk);
    endtask

    task automatic clear_model();
        m_cnt = 0;
        q_exp.delete();
        q_got.delete();
        rdy_bad = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        clear_model();
        in_val = 1'b0; str_img_rdy = 1'b0;
        #1;
        n_tests++;
        if (str_img_val !== 1'b0 || str_img_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: val=%b last=%b, expected 0 0", str_img_val, str_img_last);
        end
        n_tests++;
        if (str_img_bus !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h, expected 0", str_img_bus);
        end
        n_tests++;
        if (in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rdy: in_rdy=%b, expected 1", in_rdy);
        end
    endtask

    task automatic test_full_words();
        int low = 0;
        clear_model();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, IW'(i), (i == 8), 1'b1);
            if (s_rdy !== 1'b1) low++;
        end
        repeat (3) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            if (s_rdy !== 1'b1) low++;
        end
        n_tests++;
        if (q_got.size() != 2) begin
            n_fail++;
            $display("FAIL full_count: got %0d words, expected 2", q_got.size());
        end else begin
            n_tests++;
            if (q_got[0] !== {1'b0, 64'h0004_0003_0002_0001}) begin
                n_fail++;
                $display("FAIL full_w0: got %h, expected %h", q_got[0], {1'b0, 64'h0004_0003_0002_0001});
            end
            n_tests++;
            if (q_got[1] !== {1'b1, 64'h0008_0007_0006_0005}) begin
                n_fail++;
                $display("FAIL full_w1: got %h, expected %h", q_got[1], {1'b1, 64'h0008_0007_0006_0005});
            end
        end
        n_tests++;
        if (low != 0) begin
            n_fail++;
            $display("FAIL full_rdy: in_rdy low %0d cycles, expected 0", low);
        end
    endtask

    task automatic test_partial_word();
        clear_model();
        for (int i = 1; i <= 5; i++) cycle(1'b1, IW'(i), (i == 5), 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
        n_tests++;
        if (q_got.size() != 2) begin
            n_fail++;
            $display("FAIL part_count: got %0d words, expected 2", q_got.size());
        end else begin
            n_tests++;
            if (q_got[0] !== {1'b0, 64'h0004_0003_0002_0001}) begin
                n_fail++;
                $display("FAIL part_w0: got %h, expected %h", q_got[0], {1'b0, 64'h0004_0003_0002_0001});
            end
            n_tests++;
            if (q_got[1] !== {1'b1, 64'h0000_0000_0000_0005}) begin
                n_fail++;
                $display("FAIL part_w1: got %h, expected %h", q_got[1], {1'b1, 64'h5});
            end
        end
    endtask

    task automatic test_single_beat();
        clear_model();
        cycle(1'b1, 16'hABCD, 1'b1, 1'b1);
        n_tests++;
        if (q_got.size() != 0 || s_val !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: words=%0d val=%b, expected 0 0", q_got.size(), s_val);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        n_tests++;
        if (q_got.size() != 1) begin
            n_fail++;
            $display("FAIL single_latency: got %0d words one cycle later, expected 1", q_got.size());
        end else begin
            n_tests++;
            if (q_got[0] !== {1'b1, 64'h0000_0000_0000_ABCD}) begin
                n_fail++;
                $display("FAIL single_word: got %h, expected %h", q_got[0], {1'b1, 64'hABCD});
            end
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        int            nx = 0;
        int            guard = 0;
        int            bad_hold = 0;
        logic [OW-1:0] held_bus;
        logic          held_last;
        clear_model();
        while (nx < 6) begin
            cycle(1'b1, IW'(nx + 1), 1'b0, 1'b1);
            if (s_rdy) nx++;
        end
        s_val = 1'b0;
        while (!s_val && guard < 10) begin
            cycle(1'b1, IW'(nx + 1), 1'b0, 1'b0);
            if (!s_val && s_rdy) nx++;
            guard++;
        end
        n_tests++;
        if (!s_val) begin
            n_fail++;
            $display("FAIL bp_hold_start: val=%b after %0d cycles, expected 1", s_val, guard);
        end
        held_bus  = s_bus;
        held_last = s_last;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, IW'(nx + 1), 1'b0, 1'b0);
            if (s_bus !== held_bus || s_last !== held_last || s_val !== 1'b1 || s_rdy !== 1'b0)
                bad_hold++;
        end
        n_tests++;
        if (bad_hold != 0) begin
            n_fail++;
            $display("FAIL bp_stable: %0d stall cycles changed bus/last/val or in_rdy, expected 0", bad_hold);
        end
        guard = 0;
        while (nx < 24 && guard < 200) begin
            cycle(1'b1, IW'(nx + 1), (nx == 23), 1'b1);
            if (s_rdy) nx++;
            guard++;
        end
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
        n_tests++;
        if (q_got.size() != 6 || q_exp.size() != 6) begin
            n_fail++;
            $display("FAIL bp_count: got %0d words, model %0d, expected 6", q_got.size(), q_exp.size());
        end
        for (int i = 0; i < q_got.size() && i < q_exp.size(); i++) begin
            n_tests++;
            if (q_got[i] !== q_exp[i]) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h, expected %h", i, q_got[i], q_exp[i]);
            end
        end
        n_tests++;
        if (rdy_bad != 0) begin
            n_fail++;
            $display("FAIL bp_rdy_rule: %0d cycles violated in_rdy rule, expected 0", rdy_bad);
        end
    endtask

    task automatic test_reset_midframe();
        clear_model();
        cycle(1'b1, 16'h1111, 1'b0, 1'b1);
        cycle(1'b1, 16'h2222, 1'b0, 1'b1);
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        clear_model();
        in_val = 1'b0;
        #1;
        n_tests++;
        if (str_img_val !== 1'b0 || str_img_last !== 1'b0 || str_img_bus !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_out: val=%b last=%b bus=%h, expected 0 0 0",
                     str_img_val, str_img_last, str_img_bus);
        end
        for (int i = 1; i <= 4; i++) cycle(1'b1, IW'(i), (i == 4), 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
        n_tests++;
        if (q_got.size() != 1) begin
            n_fail++;
            $display("FAIL rst_mid_count: got %0d words, expected 1", q_got.size());
        end else begin
            n_tests++;
            if (q_got[0] !== {1'b1, 64'h0004_0003_0002_0001}) begin
                n_fail++;
                $display("FAIL rst_mid_word: got %h, expected %h", q_got[0], {1'b1, 64'h0004_0003_0002_0001});
            end
        end
    endtask

    task automatic test_random();
        int   guard = 0;
        int   start;
        logic v, l, o;
        clear_model();
        start = beats_acc;
        while ((beats_acc - start) < 1000 && guard < 10000) begin
            v = ($urandom_range(0, 9) < 7);
            o = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 7) == 0) || ((beats_acc - start) == 999);
            cycle(v, IW'($urandom), l, o);
            guard++;
        end
        n_tests++;
        if ((beats_acc - start) != 1000) begin
            n_fail++;
            $display("FAIL rand_budget: accepted %0d beats, expected 1000", beats_acc - start);
        end
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);
        n_tests++;
        if (q_got.size() != q_exp.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d words, expected %0d", q_got.size(), q_exp.size());
        end
        for (int i = 0; i < q_got.size() && i < q_exp.size(); i++) begin
            n_tests++;
            if (q_got[i] !== q_exp[i]) begin
                n_fail++;
                $display("FAIL rand_word%0d: got %h, expected %h", i, q_got[i], q_exp[i]);
            end
        end
        n_tests++;
        if (rdy_bad != 0) begin
            n_fail++;
            $display("FAIL rand_rdy_rule: %0d cycles violated in_rdy rule, expected 0", rdy_bad);
        end
    endtask

    initial begin
        rst = 1'b1; in_val = 1'b0; in_bus = '0; in_last = 1'b0; str_img_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_words();
        test_partial_word();
        test_single_beat();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
